// File: rtl/instr_encoder.sv
// Packs mnemonic + field instructions into 32-bit MIPS words and streams them
// to consecutive instruction-memory word addresses over a back-pressured write port.
module instr_encoder #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        op_sel_i,
    input  logic [4:0]        rs_i,
    input  logic [4:0]        rt_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        shamt_i,
    input  logic [5:0]        funct_i,
    input  logic [15:0]       imm_i,
    input  logic [25:0]       target_i,
    input  logic              clear_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [31:0]       wr_data_o,
    input  logic              mem_ready_i,
    output logic [ADDR_W:0]   count_o,
    output logic              full_o,
    output logic              err_o
);

    typedef enum logic [1:0] {IDLE, HOLD, FULL} state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t            stateReg, stateNext;
    logic [ADDR_W-1:0] addrReg, addrNext;
    logic [ADDR_W:0]   countReg, countNext;
    logic [31:0]       dataReg, dataNext;
    logic              errReg, errNext;
    logic [31:0]       encWord;
    logic              encLegal;

    // Opcode map shared with the CPU's control decoder.
    always_comb begin
        encWord  = 32'd0;
        encLegal = 1'b1;
        case (op_sel_i)
            4'd0:  encWord = {6'd0, rs_i, rt_i, rd_i, shamt_i, funct_i};
            4'd1:  encWord = {6'd8,  rs_i, rt_i, imm_i};
            4'd2:  encWord = {6'd13, rs_i, rt_i, imm_i};
            4'd3:  encWord = {6'd15, 5'd0, rt_i, imm_i};
            4'd4:  encWord = {6'd4,  rs_i, rt_i, imm_i};
            4'd5:  encWord = {6'd5,  rs_i, rt_i, imm_i};
            4'd6:  encWord = {6'd6,  rs_i, rt_i, imm_i};
            4'd7:  encWord = {6'd7,  rs_i, rt_i, imm_i};
            4'd8:  encWord = {6'd2,  target_i};
            4'd9:  encWord = {6'd3,  target_i};
            4'd10: encWord = {6'd35, rs_i, rt_i, imm_i};
            4'd11: encWord = {6'd43, rs_i, rt_i, imm_i};
            default: encLegal = 1'b0;
        endcase
    end

    always_comb begin
        stateNext = stateReg;
        addrNext  = addrReg;
        countNext = countReg;
        dataNext  = dataReg;
        errNext   = errReg;
        case (stateReg)
            IDLE: begin
                if (valid_i) begin
                    if (encLegal) begin
                        dataNext  = encWord;
                        stateNext = HOLD;
                    end else begin
                        errNext = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (mem_ready_i) begin
                    countNext = countReg + (ADDR_W+1)'(1);
                    // The address parks on the last slot once the buffer fills.
                    if (countNext == DEPTH_C) begin
                        stateNext = FULL;
                    end else begin
                        stateNext = IDLE;
                        addrNext  = addrReg + ADDR_W'(1);
                    end
                end
            end
            FULL: stateNext = FULL;
            default: stateNext = IDLE;
        endcase
        if (clear_i) begin
            stateNext = IDLE;
            addrNext  = '0;
            countNext = '0;
            errNext   = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stateReg <= IDLE;
            addrReg  <= '0;
            countReg <= '0;
            dataReg  <= 32'd0;
            errReg   <= 1'b0;
        end else begin
            stateReg <= stateNext;
            addrReg  <= addrNext;
            countReg <= countNext;
            dataReg  <= dataNext;
            errReg   <= errNext;
        end
    end

    assign ready_o   = (stateReg == IDLE);
    assign wr_en_o   = (stateReg == HOLD);
    assign full_o    = (stateReg == FULL);
    assign wr_addr_o = addrReg;
    assign wr_data_o = dataReg;
    assign count_o   = countReg;
    assign err_o     = errReg;

endmodule

// File: tb/tb_instr_encoder.sv
// Table-driven bench for instr_encoder with a write scoreboard; DEPTH=4 so the
// buffer fills several times and the 2-bit address hits its last slot.
module tb_instr_encoder;

    localparam int AW = 2;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic [3:0]    opSel = '0;
    logic [4:0]    rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]    funct = '0;
    logic [15:0]   imm = '0;
    logic [25:0]   target = '0;
    logic          clear = 1'b0;
    logic          wrEn;
    logic [AW-1:0] wrAddr;
    logic [31:0]   wrData;
    logic          memReady = 1'b1;
    logic [AW:0]   count;
    logic          full;
    logic          err;

    instr_encoder #(.ADDR_W(AW), .DEPTH(DP)) dut (
        .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(ready),
        .op_sel_i(opSel), .rs_i(rs), .rt_i(rt), .rd_i(rd), .shamt_i(shamt),
        .funct_i(funct), .imm_i(imm), .target_i(target), .clear_i(clear),
        .wr_en_o(wrEn), .wr_addr_o(wrAddr), .wr_data_o(wrData),
        .mem_ready_i(memReady), .count_o(count), .full_o(full), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    vec_t          vecs [12];
    logic [33:0]   expQ [$];
    int            vecCount  = 0;
    int            missCount = 0;
    int            expCount  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", nm, act);
        end
    endtask

    // Scoreboard: a write completes on the next edge when wrEn & memReady & !clear.
    always @(negedge clk) begin
        if (rst_n && wrEn && memReady && !clear) begin
            if (expQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("FAIL unexpected_write: got addr %0d data 0x%08h expected none", wrAddr, wrData);
            end else begin
                logic [33:0] e;
                e = expQ.pop_front();
                chk("write_addr", 32'(wrAddr), 32'(e[33:32]));
                chk("write_data", wrData, e[31:0]);
            end
        end
    end

    task automatic drive(input vec_t v);
        opSel = v.op; rs = v.rs; rt = v.rt; rd = v.rd; shamt = v.sh;
        funct = v.fn; imm = v.imm; target = v.tgt;
    endtask

    // Presents one instruction; returns #1 after the accepting edge.
    task automatic send(input vec_t v, input bit legal);
        int n;
        drive(v);
        valid = 1'b1;
        n = 0;
        while (!ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) chk("accept_timeout", 32'(ready), 32'd1);
        chk("wr_en_low_at_accept", 32'(wrEn), 32'd0);
        if (legal) expQ.push_back({2'(expCount), v.exp});
        @(posedge clk); #1;
        valid = 1'b0;
        if (legal) chk("wr_en_one_cycle_after_accept", 32'(wrEn), 32'd1);
    endtask

    task automatic doClear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        expCount = 0;
        chk("clear_count", 32'(count), 32'd0);
        chk("clear_addr", 32'(wrAddr), 32'd0);
        chk("clear_full", 32'(full), 32'd0);
        chk("clear_err", 32'(err), 32'd0);
        chk("clear_ready", 32'(ready), 32'd1);
    endtask

    task automatic resetChecks();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_wr_en", 32'(wrEn), 32'd0);
        chk("rst_addr", 32'(wrAddr), 32'd0);
        chk("rst_data", wrData, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        //          op    rs     rt     rd    sh     fn     imm       tgt           exp
        vecs[0]  = '{4'd1,  5'd1,  5'd2,  5'd0, 5'd0,  6'h00, 16'h0005, 26'h0,       32'h20220005};
        vecs[1]  = '{4'd0,  5'd1,  5'd2,  5'd3, 5'd0,  6'h20, 16'hFFFF, 26'h0,       32'h00221820};
        vecs[2]  = '{4'd9,  5'd0,  5'd0,  5'd0, 5'd0,  6'h00, 16'h0000, 26'h0000010, 32'h0C000010};
        vecs[3]  = '{4'd2,  5'd3,  5'd4,  5'd0, 5'd0,  6'h00, 16'hFFFF, 26'h0,       32'h3464FFFF};
        vecs[4]  = '{4'd4,  5'd1,  5'd2,  5'd0, 5'd0,  6'h00, 16'hFFFE, 26'h0,       32'h1022FFFE};
        vecs[5]  = '{4'd5,  5'd31, 5'd0,  5'd0, 5'd0,  6'h00, 16'h0010, 26'h0,       32'h17E00010};
        vecs[6]  = '{4'd6,  5'd2,  5'd3,  5'd0, 5'd0,  6'h00, 16'h0003, 26'h0,       32'h18430003};
        vecs[7]  = '{4'd7,  5'd0,  5'd31, 5'd0, 5'd0,  6'h00, 16'h8000, 26'h0,       32'h1C1F8000};
        vecs[8]  = '{4'd8,  5'd5,  5'd0,  5'd0, 5'd0,  6'h00, 16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};
        vecs[9]  = '{4'd11, 5'd29, 5'd8,  5'd0, 5'd0,  6'h00, 16'h0004, 26'h0,       32'hAFA80004};
        vecs[10] = '{4'd0,  5'd0,  5'd5,  5'd6, 5'd10, 6'h00, 16'h0000, 26'h0,       32'h00053280};
        vecs[11] = '{4'd3,  5'd7,  5'd9,  5'd0, 5'd0,  6'h00, 16'hABCD, 26'h0,       32'h3C09ABCD};

        #12;
        resetChecks();
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table: each word completes one cycle after it is raised; fill, probe, clear.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i], 1'b1);
            @(posedge clk); #1;
            expCount++;
            chk("count_after_write", 32'(count), 32'(expCount));
            chk("wr_en_after_write", 32'(wrEn), 32'd0);
            if (expCount == DP) begin
                chk("full_flag", 32'(full), 32'd1);
                chk("full_ready", 32'(ready), 32'd0);
                chk("full_addr_last_slot", 32'(wrAddr), 32'(DP - 1));
                drive(vecs[0]);
                valid = 1'b1;
                repeat (2) begin
                    @(posedge clk); #1;
                    chk("full_ignores_valid_wr_en", 32'(wrEn), 32'd0);
                    chk("full_count_hold", 32'(count), 32'(DP));
                end
                valid = 1'b0;
                doClear();
            end
        end

        // Back-pressure: LW held for three stalled cycles.
        v = '{4'd10, 5'd0, 5'd4, 5'd0, 5'd0, 6'h00, 16'h0008, 26'h0, 32'h8C040008};
        memReady = 1'b0;
        send(v, 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("bp_wr_en", 32'(wrEn), 32'd1);
            chk("bp_data", wrData, 32'h8C040008);
            chk("bp_ready", 32'(ready), 32'd0);
            chk("bp_addr", 32'(wrAddr), 32'd0);
            if (c < 2) begin
                @(posedge clk); #1;
            end
        end
        memReady = 1'b1;
        @(posedge clk); #1;
        expCount++;
        chk("bp_count_done", 32'(count), 32'd1);
        chk("bp_wr_en_done", 32'(wrEn), 32'd0);

        // Illegal op, then LI with rs forced to zero.
        v = '{4'd13, 5'd1, 5'd1, 5'd1, 5'd1, 6'h3F, 16'h1111, 26'h0, 32'h0};
        send(v, 1'b0);
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_no_wr_en", 32'(wrEn), 32'd0);
        chk("illegal_ready", 32'(ready), 32'd1);
        chk("illegal_addr", 32'(wrAddr), 32'd1);
        v = '{4'd3, 5'd7, 5'd5, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0, 32'h3C051234};
        send(v, 1'b1);
        @(posedge clk); #1;
        expCount++;
        chk("li_count", 32'(count), 32'd2);
        chk("err_sticky", 32'(err), 32'd1);

        // Clear together with mem_ready in HOLD: word dropped, no increment.
        send(vecs[0], 1'b1);
        clear = 1'b1;
        void'(expQ.pop_back());
        @(posedge clk); #1;
        clear = 1'b0;
        expCount = 0;
        chk("clr_hold_wr_en", 32'(wrEn), 32'd0);
        chk("clr_hold_count", 32'(count), 32'd0);
        chk("clr_hold_addr", 32'(wrAddr), 32'd0);
        chk("clr_hold_err", 32'(err), 32'd0);
        chk("clr_hold_ready", 32'(ready), 32'd1);

        // Asynchronous reset mid-HOLD.
        memReady = 1'b0;
        send(vecs[4], 1'b1);
        #2;
        rst_n = 1'b0;
        void'(expQ.pop_back());
        #1;
        chk("async_rst_wr_en", 32'(wrEn), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        memReady = 1'b1;
        @(posedge clk); #1;
        resetChecks();

        // One more ordinary write after reset to confirm recovery.
        send(vecs[9], 1'b1);
        @(posedge clk); #1;
        chk("post_rst_count", 32'(count), 32'd1);

        chk("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
